// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank access controller: word and index
// widths of the DiBU register bank and the sequencer state encoding.
package regbank_pkg;

  localparam int unsigned REGBANK_DW = 8;
  localparam int unsigned REGBANK_AW = 3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StCap  = 3'd2,
    StRsp  = 3'd3,
    StWr   = 3'd4
  } state_e;

endpackage

// File: rtl/txn_counter.sv
// Synchronous modulo transaction counter; wraps at 2**Width with no saturation.
module txn_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  // Count register: clear on reset, step by one on each completed transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regbank_access_ctrl.sv
// Initiator for the DiBU register bank port. Serialises operand reads and
// writebacks, hides the bank's one-cycle registered read latency and returns
// both operands over a held valid/ready response.
// Build option: REGBANK_ACCESS_CTRL_R0_ZERO_EN makes register 0 read as zero
// and suppresses bank writes to it.
module regbank_access_ctrl
  import regbank_pkg::*;
#(
  parameter int unsigned DW = REGBANK_DW,
  parameter int unsigned AW = REGBANK_AW
) (
  input  logic          clk,
  input  logic          rst,
  // request side
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_ra,
  input  logic [AW-1:0] req_rb,
  input  logic [AW-1:0] req_rd,
  input  logic [DW-1:0] req_wdata,
  // response side
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_a,
  output logic [DW-1:0] rsp_b,
  output logic          wr_done,
  output logic [7:0]    rd_count,
  output logic [7:0]    wr_count,
  // register bank pins
  output logic          bank_rw,
  output logic [AW-1:0] bank_ri_a,
  output logic [AW-1:0] bank_ri_b,
  output logic [AW-1:0] bank_ri_d,
  output logic [DW-1:0] bank_d,
  input  logic [DW-1:0] bank_a,
  input  logic [DW-1:0] bank_b
);

`ifdef REGBANK_ACCESS_CTRL_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  state_e        state_q, state_d;
  logic          accept;
  logic [AW-1:0] ra_q, rb_q, rd_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rsp_a_q, rsp_b_q;
  logic          wr_done_q;
  logic          rd_zero_a, rd_zero_b, wr_zero;
  logic          rd_inc, wr_inc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in idle.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = req_we ? StWr : StRd;
        end
      end
      StRd:    state_d = StCap;
      StCap:   state_d = StRsp;
      StRsp:   if (rsp_ready) state_d = StIdle;
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture; these registers drive the bank index/data pins directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      ra_q    <= req_ra;
      rb_q    <= req_rb;
      rd_q    <= req_rd;
      wdata_q <= req_wdata;
    end
  end

  assign rd_zero_a = R0Zero && (ra_q == '0);
  assign rd_zero_b = R0Zero && (rb_q == '0);
  assign wr_zero   = R0Zero && (rd_q == '0);

  // Operand capture one cycle after the bank sampled the read indices.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else if (state_q == StCap) begin
      rsp_a_q <= rd_zero_a ? '0 : bank_a;
      rsp_b_q <= rd_zero_b ? '0 : bank_b;
    end
  end

  // Write-commit pulse lands in the cycle the controller is back in idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_done_q <= 1'b0;
    end else begin
      wr_done_q <= (state_q == StWr);
    end
  end

  assign rd_inc = (state_q == StRsp) & rsp_ready;
  assign wr_inc = (state_q == StWr);

  txn_counter #(
    .Width (8)
  ) u_rd_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (rd_inc),
    .count (rd_count)
  );

  txn_counter #(
    .Width (8)
  ) u_wr_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (wr_inc),
    .count (wr_count)
  );

  // Gated by rst so a reset landing in the write cycle cancels the write.
  assign bank_rw   = (state_q == StWr) & ~rst & ~wr_zero;
  assign bank_ri_a = ra_q;
  assign bank_ri_b = rb_q;
  assign bank_ri_d = rd_q;
  assign bank_d    = wdata_q;

  assign rsp_valid = (state_q == StRsp);
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Directed bench for regbank_access_ctrl with a behavioural register bank
// (registered read ports, write on rw) attached to the bank pins.
module tb_regbank_access_ctrl;

`ifdef REGBANK_ACCESS_CTRL_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_ra, req_rb, req_rd;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_a, rsp_b;
  logic       wr_done;
  logic [7:0] rd_count, wr_count;
  logic       bank_rw;
  logic [2:0] bank_ri_a, bank_ri_b, bank_ri_d;
  logic [7:0] bank_d, bank_a, bank_b;

  int n_chk = 0;
  int n_err = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int bank_wr_cnt = 0;

  logic [7:0] mem [8] = '{default: 8'h00};

  always #5 clk = ~clk;

  regbank_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ra    (req_ra),
    .req_rb    (req_rb),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .wr_done   (wr_done),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .bank_rw   (bank_rw),
    .bank_ri_a (bank_ri_a),
    .bank_ri_b (bank_ri_b),
    .bank_ri_d (bank_ri_d),
    .bank_d    (bank_d),
    .bank_a    (bank_a),
    .bank_b    (bank_b)
  );

  // Register bank model: registered reads, write when rw is high.
  always @(posedge clk) begin
    if (bank_rw === 1'b1) begin
      mem[bank_ri_d] <= bank_d;
      bank_wr_cnt    <= bank_wr_cnt + 1;
    end
    bank_a <= mem[bank_ri_a];
    bank_b <= mem[bank_ri_b];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
  endtask

  // Write: accept in idle, one WR cycle, then back in idle with wr_done.
  task automatic wr(input string tag, input logic [2:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_rd    = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
    check({tag, " rw"}, bank_rw, (R0Z && a == 3'd0) ? 1'b0 : 1'b1);
    check({tag, " busy"}, req_ready, 1'b0);
    step();
    exp_wr = (exp_wr + 1) % 256;
    check({tag, " done"}, wr_done, 1'b1);
  endtask

  // Read: checks latency, operands, stability while held and the handshake.
  task automatic rd(input string tag, input logic [2:0] a, input logic [2:0] b,
                    input logic [7:0] ea, input logic [7:0] eb, input int hold);
    int lat;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_ra    = a;
    req_rb    = b;
    rsp_ready = (hold == 0);
    step();
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    check({tag, " lat"}, lat, 2);
    check({tag, " a"}, rsp_a, ea);
    check({tag, " b"}, rsp_b, eb);
    for (int i = 0; i < hold; i++) begin
      check({tag, " hold vld"}, rsp_valid, 1'b1);
      check({tag, " hold a"}, rsp_a, ea);
      check({tag, " hold b"}, rsp_b, eb);
      check({tag, " hold rdy"}, req_ready, 1'b0);
      check({tag, " hold cnt"}, rd_count, exp_rd);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_rd = (exp_rd + 1) % 256;
    check({tag, " cnt"}, rd_count, exp_rd);
    check({tag, " vld off"}, rsp_valid, 1'b0);
    check({tag, " rdy"}, req_ready, 1'b1);
  endtask

  initial begin
    int w0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_ra    = '0;
    req_rb    = '0;
    req_rd    = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    do_reset();

    check("rst ready", req_ready, 1'b1);
    check("rst valid", rsp_valid, 1'b0);
    check("rst done", wr_done, 1'b0);
    check("rst rdcnt", rd_count, 8'h00);
    check("rst wrcnt", wr_count, 8'h00);
    check("rst rw", bank_rw, 1'b0);
    check("rst idx", {bank_ri_a, bank_ri_b, bank_ri_d}, 9'h000);
    check("rst d", bank_d, 8'h00);
    check("rst rsp", {rsp_a, rsp_b}, 16'h0000);

    // 1: write then read the same register with ready held high
    wr("t1 wr", 3'd3, 8'hA5);
    check("t1 wrcnt", wr_count, exp_wr);
    step();
    check("t1 done pulse", wr_done, 1'b0);
    rd("t1 rd", 3'd3, 3'd3, 8'hA5, 8'hA5, 0);

    // 2: two writes then a read held for five cycles
    wr("t2 wr1", 3'd1, 8'h11);
    wr("t2 wr2", 3'd2, 8'h22);
    check("t2 wrcnt", wr_count, exp_wr);
    rd("t2 rd", 3'd1, 3'd2, 8'h11, 8'h22, 5);

    // 3: reset during the WR cycle cancels the write
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_rd    = 3'd4;
    req_wdata = 8'h77;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t3 rw gated", bank_rw, 1'b0);
    step();
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    check("t3 done", wr_done, 1'b0);
    check("t3 wrcnt", wr_count, 8'h00);
    check("t3 rdcnt", rd_count, 8'h00);
    check("t3 ready", req_ready, 1'b1);
    check("t3 ri_d", bank_ri_d, 3'd0);
    check("t3 d", bank_d, 8'h00);
    rd("t3 rd", 3'd4, 3'd4, 8'h00, 8'h00, 0);

    // 4: write requests while a read is in flight are ignored
    w0 = bank_wr_cnt;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_ra    = 3'd3;
    req_rb    = 3'd1;
    rsp_ready = 1'b0;
    step();
    req_we    = 1'b1;
    req_rd    = 3'd5;
    req_wdata = 8'h5A;
    step();
    step();
    check("t4 vld", rsp_valid, 1'b1);
    check("t4 a", rsp_a, 8'hA5);
    check("t4 b", rsp_b, 8'h11);
    step();
    check("t4 still vld", rsp_valid, 1'b1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_rd++;
    check("t4 rdcnt", rd_count, exp_rd);
    check("t4 wrcnt", wr_count, exp_wr);
    check("t4 no bank wr", bank_wr_cnt, w0);
    rd("t4 r5", 3'd5, 3'd5, 8'h00, 8'h00, 0);

    // 6: register 0 behaviour depends on the build option
    w0 = bank_wr_cnt;
    wr("t6 wr", 3'd0, 8'hFF);
    check("t6 wrcnt", wr_count, exp_wr);
    check("t6 bank wr", bank_wr_cnt, R0Z ? w0 : w0 + 1);
    rd("t6 rd", 3'd0, 3'd0, R0Z ? 8'h00 : 8'hFF, R0Z ? 8'h00 : 8'hFF, 0);

    // 5: write counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) wr("t5 wr", 3'd6, 8'(i));
    check("t5 cnt255", wr_count, 8'hFF);
    wr("t5 wr256", 3'd6, 8'hFF);
    check("t5 cnt wrap", wr_count, 8'h00);
    rd("t5 rd", 3'd6, 3'd6, 8'hFF, 8'hFF, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
